// File: rtl/fb_line_fetch_if.sv
// fb_line_fetch_if: AXI4 read address/data channels between the line fetcher and memory
interface fb_line_fetch_if #(
  parameter int ID_WIDTH = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0] arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic [3:0] arqos;
  logic arvalid;
  logic arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    input arready, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/fb_line_fetch.sv
// fb_line_fetch: AXI4 read-burst engine fetching one framebuffer line into the scan-out line buffer
module fb_line_fetch #(
  parameter logic [31:0] C_M00_AXI_TARGET_SLAVE_BASE_ADDR = 32'h8100_0000,
  parameter int C_M00_AXI_BURST_LEN = 64,
  parameter int C_M00_AXI_ID_WIDTH = 1,
  parameter int C_M00_AXI_ADDR_WIDTH = 32,
  parameter int C_M00_AXI_DATA_WIDTH = 64,
  parameter int H_PIXELS = 640,
  parameter int V_LINES = 480
) (
  input  logic m00_axi_aclk,
  input  logic m00_axi_areset,
  input  logic init_read_line,
  input  logic [8:0] line_idx,
  input  logic fb_sel,
  output logic busy,
  output logic line_done,
  output logic error,
  output logic buf_we,
  output logic [8:0] buf_waddr,
  output logic [C_M00_AXI_DATA_WIDTH-1:0] buf_wdata,
  fb_line_fetch_if.master m00_axi
);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DONE = 2'd3;
  localparam int BW = $clog2(C_M00_AXI_BURST_LEN);
  localparam int NB = H_PIXELS * 32 / C_M00_AXI_DATA_WIDTH / C_M00_AXI_BURST_LEN;
  localparam int BURST_BYTES = C_M00_AXI_BURST_LEN * C_M00_AXI_DATA_WIDTH / 8;
  localparam int LINE_BYTES = H_PIXELS * 4;
  localparam int FB_BYTES = LINE_BYTES * V_LINES;
  logic [1:0] state;
  logic [C_M00_AXI_ADDR_WIDTH-1:0] line_base;
  logic [2:0] burst_idx;
  logic [BW-1:0] beat;
  logic r_hs, last_beat, burst_end, final_burst;
  assign r_hs = m00_axi.rvalid && m00_axi.rready;
  assign last_beat = beat == BW'(C_M00_AXI_BURST_LEN - 1);
  // a burst closes on whichever comes first: the slave's rlast or our own beat count
  assign burst_end = r_hs && (m00_axi.rlast || last_beat);
  assign final_burst = burst_idx == 3'(NB - 1);
  assign busy = state != IDLE;
  assign line_done = state == DONE;
  assign m00_axi.arvalid = state == ADDR;
  assign m00_axi.rready = state == DATA;
  assign m00_axi.araddr = line_base + C_M00_AXI_ADDR_WIDTH'(burst_idx * BURST_BYTES);
  assign m00_axi.arid = C_M00_AXI_ID_WIDTH'(0);
  assign m00_axi.arlen = 8'(C_M00_AXI_BURST_LEN - 1);
  assign m00_axi.arsize = 3'b011;
  assign m00_axi.arburst = 2'b01;
  assign m00_axi.arlock = 1'b0;
  assign m00_axi.arcache = 4'b0011;
  assign m00_axi.arprot = 3'b000;
  assign m00_axi.arqos = 4'b0000;
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      state <= IDLE;
      line_base <= '0;
      burst_idx <= '0;
      beat <= '0;
      error <= 1'b0;
      buf_we <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
    end else begin
      buf_we <= r_hs;
      if (r_hs) begin
        buf_waddr <= 9'(burst_idx * C_M00_AXI_BURST_LEN) + 9'(beat);
        buf_wdata <= m00_axi.rdata;
        beat <= burst_end ? '0 : beat + 1'b1;
        // rlast must coincide exactly with the final beat; any other pairing is a protocol error
        error <= error | (m00_axi.rresp != 2'b00) | (m00_axi.rlast != last_beat);
      end
      if (state == IDLE && init_read_line) begin
        state <= ADDR;
        line_base <= C_M00_AXI_ADDR_WIDTH'(C_M00_AXI_TARGET_SLAVE_BASE_ADDR
                     + (fb_sel ? 32'(FB_BYTES) : 32'd0) + 32'(line_idx) * 32'(LINE_BYTES));
        burst_idx <= '0;
        beat <= '0;
        error <= 1'b0;
      end
      if (state == ADDR && m00_axi.arready) state <= DATA;
      if (burst_end) begin
        state <= final_burst ? DONE : ADDR;
        burst_idx <= final_burst ? burst_idx : burst_idx + 1'b1;
      end
      if (state == DONE) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_fb_line_fetch.sv
// tb_fb_line_fetch: vector table, reset corner and randomized lines checked against a line-fetch model
module tb_fb_line_fetch;
  logic clk = 1'b0, rst = 1'b1, init_read_line = 1'b0, fb_sel = 1'b0;
  logic [8:0] line_idx = '0;
  logic busy, line_done, error, buf_we;
  logic [8:0] buf_waddr;
  logic [63:0] buf_wdata;
  fb_line_fetch_if ax();
  fb_line_fetch dut (
    .m00_axi_aclk(clk), .m00_axi_areset(rst), .init_read_line(init_read_line),
    .line_idx(line_idx), .fb_sel(fb_sel), .busy(busy), .line_done(line_done),
    .error(error), .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .m00_axi(ax.master)
  );
  always #5 clk = ~clk;
  typedef struct {
    int line; bit fb; int dly; int gap; int kind; int ib; int ibeat;
    logic [31:0] first_a; logic [31:0] last_a; int nwr; bit err; int spot_w; logic [31:0] spot_a;
  } vec_t;
  int n_tests = 0, n_fail = 0;
  int cfg_dly = 0, cfg_gap = 0, inj_kind = 0, inj_b = 0, inj_beat = 0;
  int bnum = 0, sbeat = 0, ar_cnt = 0, cyc = 0, done_cnt = 0, done_cyc = 0, last_we_cyc = 0, stab_err = 0;
  bit ar_go = 0, r_go = 0, ar_wait = 0;
  logic [31:0] ar_a, wait_a;
  logic [31:0] q[$];
  logic [31:0] ar_log[$];
  logic [72:0] wr_log[$];
  function automatic logic [63:0] word(input logic [31:0] a);
    return {a ^ 32'h5A5A_0F0F, ~a};
  endfunction
  function automatic logic [31:0] mbase(input int line, input bit fb);
    return 32'h8100_0000 + (fb ? 32'h0012_C000 : 32'd0) + 32'(line) * 32'd2560;
  endfunction
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // memory slave plus output monitor, all on the falling edge
  initial begin
    ax.arready = 0; ax.rvalid = 0; ax.rlast = 0; ax.rresp = 0; ax.rdata = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (buf_we) begin wr_log.push_back({buf_waddr, buf_wdata}); last_we_cyc = cyc; end
      if (line_done) begin done_cnt++; done_cyc = cyc; end
      if (ar_wait && busy && !(ax.arvalid && ax.araddr == wait_a)) stab_err++;
      if (!busy) begin q.delete(); sbeat = 0; ar_go = 0; r_go = 0; ar_cnt = 0; end
      if (ar_go) begin q.push_back(ar_a); ar_log.push_back(ar_a); ar_cnt = 0; end
      if (r_go) begin
        if (ax.rlast || sbeat == 63) begin q.delete(0); sbeat = 0; bnum++; end
        else sbeat++;
      end
      ax.arready = ax.arvalid && ar_cnt >= cfg_dly;
      if (ax.arvalid && !ax.arready) ar_cnt++;
      ar_wait = ax.arvalid && !ax.arready;
      wait_a = ax.araddr;
      if (q.size() > 0) begin
        ax.rvalid = cfg_gap == 0 ? 1'b1 : cfg_gap == 1 ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
        ax.rdata = word(q[0] + 32'(sbeat) * 8);
        ax.rresp = (inj_kind == 1 && bnum == inj_b && sbeat == inj_beat) ? 2'b10 : 2'b00;
        ax.rlast = (inj_kind == 2 && bnum == inj_b) ? sbeat == inj_beat :
                   (inj_kind == 3 && bnum == inj_b) ? 1'b0 : sbeat == 63;
      end else begin
        ax.rvalid = 0; ax.rlast = 0; ax.rresp = 0;
      end
      ar_go = ax.arvalid && ax.arready;
      ar_a = ax.araddr;
      r_go = ax.rvalid && ax.rready;
    end
  end
  task automatic setup(input vec_t v);
    cfg_dly = v.dly; cfg_gap = v.gap; inj_kind = v.kind; inj_b = v.ib; inj_beat = v.ibeat;
    bnum = 0; ar_log.delete(); wr_log.delete(); done_cnt = 0; stab_err = 0;
  endtask
  task automatic run(input vec_t v);
    logic [31:0] base;
    logic [72:0] exp_wr[$];
    logic [63:0] got;
    int bad;
    base = mbase(v.line, v.fb);
    setup(v);
    for (int k = 0; k < 5; k++)
      for (int b = 0; b < 64; b++)
        if (!(v.kind == 2 && k == v.ib && b > v.ibeat))
          exp_wr.push_back({9'(k * 64 + b), word(base + 32'(k * 512 + b * 8))});
    @(negedge clk);
    init_read_line = 1; line_idx = 9'(v.line); fb_sel = v.fb;
    @(negedge clk);
    init_read_line = 0;
    check("busy_on", busy, 1);
    check("arvalid_on", ax.arvalid, 1);
    check("error_cleared", error, 0);
    line_idx = ~line_idx; fb_sel = ~fb_sel; init_read_line = 1;
    @(negedge clk);
    init_read_line = 0;
    for (int n = 0; n < 6000 && done_cnt == 0; n++) @(posedge clk);
    repeat (2) @(negedge clk);
    @(posedge clk);
    check("line_done_once", done_cnt, 1);
    check("busy_off", busy, 0);
    check("error", error, v.err);
    check("ar_count", ar_log.size(), 5);
    if (ar_log.size() == 5) begin
      check("ar_first", ar_log[0], v.first_a);
      check("ar_last", ar_log[4], v.last_a);
    end
    bad = 0;
    foreach (ar_log[k]) if (ar_log[k] !== base + 32'(k * 512)) bad++;
    check("ar_seq", bad, 0);
    check("ar_stable", stab_err, 0);
    check("we_count", wr_log.size(), v.nwr);
    bad = 0;
    foreach (exp_wr[i]) if (i >= wr_log.size() || wr_log[i] !== exp_wr[i]) bad++;
    check("wr_seq", bad, 0);
    got = 'x;
    foreach (wr_log[i]) if (wr_log[i][72:64] == 9'(v.spot_w)) got = wr_log[i][63:0];
    check("spot_word", got, word(v.spot_a));
    check("done_after_last_we", done_cyc, last_we_cyc);
  endtask
  vec_t tbl[8];
  vec_t v;
  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 32'h8100_0000, 32'h8100_0800, 320, 0, 5, 32'h8100_0028};
    tbl[1] = '{479, 1, 0, 0, 0, 0, 0, 32'h8125_7600, 32'h8125_7E00, 320, 0, 319, 32'h8125_7FF8};
    tbl[2] = '{0, 0, 10, 1, 0, 0, 0, 32'h8100_0000, 32'h8100_0800, 320, 0, 100, 32'h8100_0320};
    tbl[3] = '{0, 0, 0, 0, 1, 2, 5, 32'h8100_0000, 32'h8100_0800, 320, 1, 133, 32'h8100_0428};
    tbl[4] = '{2, 1, 2, 2, 0, 0, 0, 32'h8112_D400, 32'h8112_DC00, 320, 0, 0, 32'h8112_D400};
    tbl[5] = '{0, 0, 0, 0, 2, 0, 31, 32'h8100_0000, 32'h8100_0800, 288, 1, 64, 32'h8100_0200};
    tbl[6] = '{0, 0, 1, 0, 3, 4, 0, 32'h8100_0000, 32'h8100_0800, 320, 1, 319, 32'h8100_09F8};
    tbl[7] = '{1, 0, 0, 0, 0, 0, 0, 32'h8100_0A00, 32'h8100_1200, 320, 0, 0, 32'h8100_0A00};
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_line_done", line_done, 0);
    check("rst_error", error, 0);
    check("rst_buf_we", buf_we, 0);
    check("rst_buf_waddr", buf_waddr, 0);
    check("rst_arvalid", ax.arvalid, 0);
    check("rst_rready", ax.rready, 0);
    check("rst_araddr", ax.araddr, 0);
    check("arlen", ax.arlen, 63);
    check("arsize", ax.arsize, 3);
    check("arburst", ax.arburst, 1);
    check("arcache", ax.arcache, 3);
    for (int i = 0; i < 7; i++) run(tbl[i]);
    // reset in the middle of burst 3, then a fresh request must restart cleanly
    setup(tbl[0]);
    @(negedge clk);
    init_read_line = 1; line_idx = 0; fb_sel = 0;
    @(negedge clk);
    init_read_line = 0;
    for (int n = 0; n < 3000 && ar_log.size() < 4; n++) @(posedge clk);
    repeat (3) @(negedge clk);
    check("mid_reset_in_burst3", bnum, 3);
    rst = 1;
    @(negedge clk);
    check("mid_rst_arvalid", ax.arvalid, 0);
    check("mid_rst_rready", ax.rready, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    check("mid_rst_no_done", done_cnt, 0);
    run(tbl[7]);
    for (int r = 0; r < 20; r++) begin
      v.line = $urandom_range(0, 479);
      v.fb = 1'($urandom_range(0, 1));
      v.dly = $urandom_range(0, 3);
      v.gap = $urandom_range(0, 2);
      v.kind = $urandom_range(0, 3);
      v.ib = $urandom_range(0, 4);
      v.ibeat = v.kind == 2 ? $urandom_range(0, 62) : $urandom_range(0, 63);
      v.first_a = mbase(v.line, v.fb);
      v.last_a = v.first_a + 32'h800;
      v.nwr = v.kind == 2 ? 320 - (63 - v.ibeat) : 320;
      v.err = v.kind != 0;
      v.spot_w = $urandom_range(0, 319);
      if (v.kind == 2 && v.spot_w / 64 == v.ib && v.spot_w % 64 > v.ibeat) v.spot_w = 0;
      v.spot_a = v.first_a + 32'(v.spot_w) * 8;
      run(v);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_line_fetch.md
Name: fb_line_fetch

Overview:
- AXI4 read-burst engine for the framebuffer scan-out path.
- On a line request it fetches one full 640-pixel line of 32-bit pixels from DDR: 320 64-bit beats, issued as 5 INCR bursts of 64 beats.
- It writes each beat into the line buffer that the HDMI/VGA pixel stage reads.
- It is the AXI master front-end directly upstream of the pixel output stage, and is driven by that stage's init_read_line pulse.

Parameters:
- C_M00_AXI_TARGET_SLAVE_BASE_ADDR, 32'h81000000, byte address of framebuffer 0.
- C_M00_AXI_BURST_LEN, 64, beats per burst.
- C_M00_AXI_ID_WIDTH, 1, ARID width.
- C_M00_AXI_ADDR_WIDTH, 32, address width.
- C_M00_AXI_DATA_WIDTH, 64, data width (2 pixels per beat).
- H_PIXELS, 640, pixels per line.
- V_LINES, 480, lines per frame.

Ports:
- m00_axi_aclk  in  1  sole clock.
- m00_axi_areset  in  1  synchronous, active-high reset.
- init_read_line  in  1  one-cycle line request; ignored while busy=1.
- line_idx  in  9  line number 0..479, sampled with init_read_line.
- fb_sel  in  1  0 = fb0, 1 = fb1 (fb1 base = fb0 base + 0x12C000); sampled with init_read_line.
- busy  out  1  high from the cycle after request acceptance until line_done.
- line_done  out  1  one-cycle pulse after the 5th burst completes.
- error  out  1  sticky error flag; cleared on the next accepted request.
- buf_we  out  1  line-buffer write strobe.
- buf_waddr  out  9  beat index 0..319.
- buf_wdata  out  64  beat data (low word = even pixel).
- m00_axi_arid  out  ID_WIDTH  constant 0.
- m00_axi_araddr  out  32  burst byte address.
- m00_axi_arlen  out  8  constant BURST_LEN-1 (63).
- m00_axi_arsize  out  3  constant 3'b011.
- m00_axi_arburst  out  2  constant 2'b01 (INCR).
- m00_axi_arlock  out  1  constant 0.
- m00_axi_arcache  out  4  constant 4'b0011.
- m00_axi_arprot  out  3  constant 0.
- m00_axi_arqos  out  4  constant 0.
- m00_axi_arvalid  out  1  address valid.
- m00_axi_arready  in  1  address ready.
- m00_axi_rdata  in  64  read data.
- m00_axi_rresp  in  2  read response.
- m00_axi_rlast  in  1  last beat of burst.
- m00_axi_rvalid  in  1  read data valid.
- m00_axi_rready  out  1  read data ready.

Behaviour:
- Reset values: busy, line_done, error, buf_we, arvalid and rready are 0; buf_waddr, araddr and all counters are 0.
- A reset mid-operation aborts immediately to IDLE; beats still in flight after reset are not accepted.
- Line base address: BASE + fb_sel*0x12C000 + line_idx*2560 (all 32-bit arithmetic). Burst k (0..4) address = line base + k*512.
- Every burst is 512-byte aligned, so no burst crosses a 4 KB boundary.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: on init_read_line=1, latch the line base, set burst_idx=0, clear error, and go to ADDR. busy=1 and arvalid=1 from the next cycle (request-to-arvalid latency 1).
- ADDR: arvalid held high with araddr stable until arvalid&arready. On that handshake: arvalid->0 next cycle, go to DATA.
- DATA: rready=1 throughout.
- Each rvalid&rready handshake: buf_we=1, buf_wdata=rdata and buf_waddr=burst_idx*64+beat, all registered with 1-cycle latency; beat increments.
- Burst ends on the handshake where rlast=1 or beat=63, whichever comes first.
- Burst end with burst_idx<4: burst_idx+1, return to ADDR; arvalid rises the next cycle.
- Burst end with burst_idx=4: go to DONE.
- DONE: line_done=1 for one cycle, busy->0, return to IDLE. A new request is accepted in the following IDLE cycle.
- Error set (sticky) when:
  - rresp!=2'b00 on any beat;
  - rlast=1 on beat<63;
  - rlast=0 on beat 63.
- An error does not stall the FSM: remaining bursts are still issued and line_done still pulses.
- After an early rlast, the remaining buffer addresses of that burst are not written.
- init_read_line while busy=1 is ignored: no state change, no error.
- Gaps in rvalid produce no buf_we; buf_waddr only advances on handshakes.

Test Plan:
- Line 0, fb0, arready immediate, rvalid continuous -> araddr sequence 0x81000000, 0x81000200, 0x81000400, 0x81000600, 0x81000800. Exactly 320 buf_we with buf_waddr 0..319; buf_wdata[waddr 5] equals the slave word at 0x81000028; single line_done; error=0.
- Line 479, fb1 -> first araddr 0x81257600, last 0x81257E00; buf_waddr 319 holds the word at 0x81257FF8.
- arready delayed 10 cycles, rvalid toggling every other cycle -> arvalid and araddr stable throughout the wait. buf_we count is 320 and equals the handshake count; line_done is 1 cycle after the final burst ends.
- rresp=2'b10 on beat 5 of burst 2 -> error=1 and stays high. All 5 bursts still issued, line_done pulses, and the next init_read_line clears error.
- rlast asserted on beat 31 of burst 0 -> error=1. Burst 1 is issued with araddr base+0x200 and its first write is buf_waddr 64.
- Reset pulse during burst 3 -> next cycle arvalid=0, rready=0, busy=0, no line_done. A following request for line 1 restarts at 0x81000A00.
